// File: rtl/mux4x8to4_c.sv
// mux4x8to4_c: eight-way, 4-bit-wide selector with a registered copy.
//
// Routes one of eight 4-bit words to a combinational output under a 3-bit
// select, and provides a registered copy of that output for synchronous
// consumers.
//
// Ports
//   clk          in   1  rising-edge clock, used only by out_q
//   rst          in   1  asynchronous active-high reset, clears out_q only
//   in_0..in_7   in   4  data words; in_k is routed when select == k
//   select       in   3  unsigned index 0-7
//   out          out  4  combinational selected word (not registered)
//   out_q        out  4  out captured on each rising clk edge
module mux4x8to4_c (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_0,
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  input  logic [3:0] in_3,
  input  logic [3:0] in_4,
  input  logic [3:0] in_5,
  input  logic [3:0] in_6,
  input  logic [3:0] in_7,
  input  logic [2:0] select,
  output logic [3:0] out,
  output logic [3:0] out_q
);

  localparam int unsigned DATA_W = 4;

  // Bitwise 2:1 mux, y = (~s & a) | (s & b), replicated across the word.
  function automatic logic [DATA_W-1:0] mux2(
    input logic              s,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return (~{DATA_W{s}} & a) | ({DATA_W{s}} & b);
  endfunction

  logic [DATA_W-1:0] lvl1_01;
  logic [DATA_W-1:0] lvl1_23;
  logic [DATA_W-1:0] lvl1_45;
  logic [DATA_W-1:0] lvl1_67;
  logic [DATA_W-1:0] lvl2_lo;
  logic [DATA_W-1:0] lvl2_hi;

  // Level 1: select[0] chooses within each adjacent pair.
  assign lvl1_01 = mux2(select[0], in_0, in_1);
  assign lvl1_23 = mux2(select[0], in_2, in_3);
  assign lvl1_45 = mux2(select[0], in_4, in_5);
  assign lvl1_67 = mux2(select[0], in_6, in_7);

  // Level 2: select[1] chooses between pairs within each half.
  assign lvl2_lo = mux2(select[1], lvl1_01, lvl1_23);
  assign lvl2_hi = mux2(select[1], lvl1_45, lvl1_67);

  // Level 3: select[2] chooses the half; out never sees clk or rst.
  assign out = mux2(select[2], lvl2_lo, lvl2_hi);

  // Registered copy; reset clears it immediately without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux4x8to4_c.sv
// Directed self-checking bench for mux4x8to4_c: combinational sweeps with the
// clock stopped, then the registered path and asynchronous reset behaviour.
module tb_mux4x8to4_c;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [3:0] din [8];
  logic [2:0] select;
  logic [3:0] out;
  logic [3:0] out_q;

  int n_checks = 0;
  int n_fail   = 0;

  mux4x8to4_c dut (
    .clk    (clk),
    .rst    (rst),
    .in_0   (din[0]),
    .in_1   (din[1]),
    .in_2   (din[2]),
    .in_3   (din[3]),
    .in_4   (din[4]),
    .in_5   (din[5]),
    .in_6   (din[6]),
    .in_7   (din[7]),
    .select (select),
    .out    (out),
    .out_q  (out_q)
  );

  // Gated clock so the combinational tests run with no edges at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    clk_en = 1'b0;
    rst    = 1'b1;
    select = 3'd0;
    for (int k = 0; k < 8; k++) din[k] = 4'b0000;
    #1;
    check("reset_out_q_no_clock", out_q, 4'b0000);

    // in_k = k, sweep select; rst held high to show out ignores it.
    for (int k = 0; k < 8; k++) din[k] = 4'(k);
    for (int k = 0; k < 8; k++) begin
      select = 3'(k);
      #10;
      check($sformatf("ident_sel%0d", k), out, 4'(k));
    end
    check("out_q_held_in_reset", out_q, 4'b0000);
    rst = 1'b0;

    // in_k = ~k exercises every bit in the opposite polarity.
    for (int k = 0; k < 8; k++) din[k] = ~4'(k);
    for (int k = 0; k < 8; k++) begin
      select = 3'(k);
      #10;
      check($sformatf("inv_sel%0d", k), out, 4'(15 - k));
    end

    // Walking one on in_3.
    for (int k = 0; k < 8; k++) din[k] = 4'b0000;
    din[3] = 4'b1000;
    select = 3'd3;
    #10;
    check("walk_sel3", out, 4'b1000);
    select = 3'd2;
    #10;
    check("walk_sel2", out, 4'b0000);
    check("out_q_no_clock_still_zero", out_q, 4'b0000);

    // Registered path.
    rst = 1'b1;
    #3;
    rst = 1'b0;
    din[5] = 4'b1010;
    din[6] = 4'b0110;
    select = 3'd5;
    #2;
    check("reg_out_pre_edge", out, 4'b1010);
    check("reg_out_q_pre_edge", out_q, 4'b0000);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reg_first_capture", out_q, 4'b1010);
    @(negedge clk);
    select = 3'd6;
    #1;
    check("reg_mid_cycle_out", out, 4'b0110);
    check("reg_mid_cycle_out_q_held", out_q, 4'b1010);
    @(posedge clk);
    #1;
    check("reg_second_capture", out_q, 4'b0110);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_out_q", out_q, 4'b0000);
    check("async_rst_out_tracks", out, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_held_edge%0d", i), out_q, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_before_edge", out_q, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_release_capture", out_q, 4'b0110);

    // Input change after an edge is invisible until the next edge.
    din[6] = 4'b1100;
    #1;
    check("late_change_out", out, 4'b1100);
    check("late_change_out_q_held", out_q, 4'b0110);
    @(posedge clk);
    #1;
    check("late_change_capture", out_q, 4'b1100);

    clk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
